// File: rtl/xilly_pack_pkg.sv
// Shared types and sizes for the Xillybus 8-to-32 byte packer.
package xilly_pack_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;
  localparam int unsigned ACC_W  = (LANES - 1) * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(LANES);

  // Pending-byte count (0..LANES-1) and a one-bit-wider lane count (0..LANES).
  typedef logic [CNT_W-1:0] lane_cnt_t;
  typedef logic [CNT_W:0]   lane_num_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pack_state_t;

endpackage

// File: rtl/xilly_pack8to32.sv
// Packs the Xillybus 8-bit host stream into 32-bit FIFO words with back-pressure.
// XILLY_PACK_FLUSH_EN: when defined, a partial word at stream close is padded and written.
module xilly_pack8to32
  import xilly_pack_pkg::*;
#(
  parameter bit         BIG_ENDIAN = 1'b0,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        in_open,
  input  logic        in_wren,
  input  logic [7:0]  in_data,
  output logic        in_full,
  output logic        out_wren,
  output logic [31:0] out_data,
  input  logic        out_full,
  output logic        out_partial
);

  pack_state_t              state, state_nxt;
  logic [ACC_W-1:0]         acc, acc_nxt;
  lane_cnt_t                cnt, cnt_nxt;
  logic [WORD_W-1:0]        oreg, oreg_nxt;
  logic                     ovalid, ovalid_nxt;
  logic                     accept;
  logic                     cnt_last;
`ifdef XILLY_PACK_FLUSH_EN
  logic                     opart, opart_nxt;
`endif

  // Lanes below nvalid come from bytes_le (first byte in lane 0); the rest get PAD_BYTE.
  function automatic logic [WORD_W-1:0] build_word(input logic [WORD_W-1:0] bytes_le,
                                                   input lane_num_t         nvalid);
    logic [WORD_W-1:0] w;
    logic [BYTE_W-1:0] b;
    w = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      b = (i < int'(nvalid)) ? bytes_le[i*BYTE_W +: BYTE_W] : PAD_BYTE;
      if (BIG_ENDIAN) w[(int'(LANES) - 1 - i)*int'(BYTE_W) +: BYTE_W] = b;
      else            w[i*BYTE_W +: BYTE_W] = b;
    end
    return w;
  endfunction

  assign out_wren = ovalid && !out_full;
  assign out_data = oreg;
  assign cnt_last = (cnt == lane_cnt_t'(LANES - 1));

`ifdef XILLY_PACK_FLUSH_EN
  assign in_full     = (state == FLUSH) || (cnt_last && ovalid);
  assign out_partial = opart;
`else
  assign in_full     = cnt_last && ovalid;
  assign out_partial = 1'b0;
`endif

  assign accept = in_wren && !in_full && (state == RUN);

  // State and datapath registers.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      oreg   <= '0;
      ovalid <= 1'b0;
`ifdef XILLY_PACK_FLUSH_EN
      opart  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      oreg   <= oreg_nxt;
      ovalid <= ovalid_nxt;
`ifdef XILLY_PACK_FLUSH_EN
      opart  <= opart_nxt;
`endif
    end
  end

  // Next-state and datapath update; the output slot frees itself on transfer.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    oreg_nxt   = oreg;
    ovalid_nxt = ovalid && !out_wren;
`ifdef XILLY_PACK_FLUSH_EN
    opart_nxt  = opart;
`endif

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in_open) state_nxt = RUN;
      end

      RUN: begin
        if (accept) begin
          if (cnt_last) begin
            oreg_nxt   = build_word({in_data, acc}, lane_num_t'(LANES));
            ovalid_nxt = 1'b1;
`ifdef XILLY_PACK_FLUSH_EN
            opart_nxt  = 1'b0;
`endif
            cnt_nxt    = '0;
          end else begin
            for (int i = 0; i < int'(LANES) - 1; i++) begin
              if (cnt == lane_cnt_t'(i)) acc_nxt[i*BYTE_W +: BYTE_W] = in_data;
            end
            cnt_nxt = cnt + lane_cnt_t'(1);
          end
        end
        // Close decisions use the count after this cycle's byte.
        if (!in_open) begin
          if (cnt_nxt == '0) begin
            state_nxt = IDLE;
          end else begin
`ifdef XILLY_PACK_FLUSH_EN
            state_nxt = FLUSH;
`else
            state_nxt = IDLE;
            cnt_nxt   = '0;
`endif
          end
        end
      end

`ifdef XILLY_PACK_FLUSH_EN
      FLUSH: begin
        if (!ovalid || out_wren) begin
          oreg_nxt   = build_word({{BYTE_W{1'b0}}, acc}, lane_num_t'(cnt));
          ovalid_nxt = 1'b1;
          opart_nxt  = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: doc/xilly_pack8to32.md
# xilly_pack8to32

Byte-to-word packer sitting between the Xillybus 8-bit CPU-to-FPGA stream (`user_w_write_8_*`) and a 32-bit FIFO write port such as the 32x512 loopback FIFO. It gathers four consecutive bytes into one 32-bit word, honours the FIFO's full flag and back-pressures the host stream. When the host closes the stream with a partial word pending, it handles the remainder as selected by a build-time macro.

## Interface
Parameters:
- `BIG_ENDIAN`, 0: 0 places the first byte in [7:0]; 1 places it in [31:24].
- `PAD_BYTE`, 8'h00: fill value for unused lanes of a flushed partial word.

Ports:
- `bus_clk`  in  1  the single clock for all logic.
- `bus_rst_n`  in  1  asynchronous, active-low reset.
- `in_open`  in  1  host stream open, driven from `user_w_write_8_open`.
- `in_wren`  in  1  byte strobe, driven from `user_w_write_8_wren`.
- `in_data`  in  8  byte data.
- `in_full`  out  1  back-pressure to `user_w_write_8_full`.
- `out_wren`  out  1  FIFO write strobe.
- `out_data`  out  32  FIFO write data.
- `out_full`  in  1  FIFO full.
- `out_partial`  out  1  high with `out_wren` when the word is a padded flush word.

## Operation
- State: `acc[23:0]` (pending bytes), `cnt[1:0]` (pending byte count, 0..3), `oreg[31:0]`, `ovalid`, `opart`, and FSM `IDLE` / `RUN` / `FLUSH`.
- `out_wren = ovalid && !out_full`. `out_data = oreg`. `out_partial = opart`. A word transfers on any cycle where `out_wren` is high. `ovalid` clears on transfer unless it is reloaded in the same cycle.
- `in_full = (state == FLUSH) || (cnt == 3 && ovalid)`. The signal is combinational.
- A byte is accepted when `in_wren && !in_full && state == RUN`. A `wren` while `in_full` is high, or outside `RUN`, is dropped.
- Accepted byte with `cnt < 3`: the byte goes into lane `cnt` of `acc`, and `cnt` increments.
- Accepted byte with `cnt == 3`: `oreg` loads the assembled word per `BIG_ENDIAN`, `ovalid` is set, `opart` is cleared, and `cnt` goes to 0.
- FSM transitions:
  - `IDLE` to `RUN` on `in_open` high. `cnt` is 0 on entry.
  - `RUN` with `in_open` low and `cnt == 0`: go to `IDLE`.
  - `RUN` with `in_open` low and `cnt > 0`: behaviour set by the macro (see Configuration).
  - `FLUSH`: waits until `ovalid` is 0 or the current word is transferring this cycle. It then loads `oreg` with the `cnt` valid lanes plus `PAD_BYTE` in the rest, sets `ovalid` and `opart`, sets `cnt` to 0, and goes to `IDLE`.
- A word already in `oreg` when `in_open` falls is always delivered.
- `in_open` reasserting during `FLUSH` has no effect until `FLUSH` completes. `IDLE` then enters `RUN` on the next cycle.
- Reset mid-word or mid-flush discards all pending data. No partial write is ever issued.

## Timing
- Reset values: `in_full`=0, `out_wren`=0, `out_data`=0, `out_partial`=0, `cnt`=0, state `IDLE`.
- Latency from the 4th accepted byte to `out_wren` is 1 cycle when `out_full` is low.
- Sustained throughput is 1 byte per cycle with no stall while the FIFO keeps `out_full` low.
- A flush word appears 1 cycle after entering `FLUSH` when `oreg` is empty. When `oreg` is held by `out_full`, the flush word loads in the same cycle the held word transfers.
- `out_full` stalls `oreg` indefinitely. `in_full` rises only when a 4th byte would need the occupied `oreg`.

## Configuration
- `XILLY_PACK_FLUSH_EN` defined: `RUN` with `in_open` low and `cnt > 0` goes to `FLUSH`. The partial word is padded and written with `out_partial` high.
- `XILLY_PACK_FLUSH_EN` undefined: `RUN` with `in_open` low and `cnt > 0` goes to `IDLE` and clears `cnt`. Bytes of an incomplete word are discarded. The `FLUSH` state is not built, and `out_partial` is tied to 0.

## Structure
- Shared package `xilly_pack_pkg` holds:
  - the state enum `pack_state_t` (`IDLE`, `RUN`, `FLUSH`);
  - `LANES = 4`;
  - the lane-count type.
- Single module. No sub-module: the assemble/pad mux is a local function inside the module.

## Test plan
- Open the stream, write bytes 11,22,33,44 on consecutive cycles with `BIG_ENDIAN`=0 -> one `out_wren` with `out_data` 32'h44332211, one cycle after byte 44. `out_partial`=0.
- Same bytes with `BIG_ENDIAN`=1 -> `out_data` 32'h11223344.
- Hold `out_full`=1, write 8 bytes -> `in_full` rises after byte 7 is accepted. Release `out_full` -> two words transfer in order. Byte 8 is not lost.
- With `XILLY_PACK_FLUSH_EN`: write AA,BB then drop `in_open` -> one word 32'h0000BBAA with `out_partial`=1. `in_full` is high during `FLUSH`.
- Without the macro: the same stimulus -> no `out_wren`. A following open plus 01,02,03,04 -> 32'h04030201.
- Assert `bus_rst_n`=0 after 3 bytes -> all outputs 0. After release and a new open, the next 4 bytes form a clean word.
